// File: rtl/write_master_pkg.sv
// write_master_pkg
//   Shared definitions for the burst write master:
//   - wm_state_t : transfer sequencer states
//   - be_mask()  : byte-enable mask for a partial final word
package write_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT_DATA,
    BURST,
    DONE
  } wm_state_t;

  // Widest byte-enable the mask helper can produce (DATA_W up to 1024).
  localparam int BE_MAX_W = 128;

  // Returns the low rem_bytes bits set. A remainder of zero means the final
  // word is full, so every byte lane is enabled.
  function automatic logic [BE_MAX_W-1:0] be_mask(input int unsigned rem_bytes);
    logic [BE_MAX_W-1:0] m;
    m = '0;
    if (rem_bytes == 0) begin
      m = '1;
    end else begin
      for (int i = 0; i < BE_MAX_W; i++) begin
        if (i < int'(rem_bytes)) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wm_burst_sizer.sv
// wm_burst_sizer
//   Combinational helper for the burst write master.
//   Ports:
//     words_rem   : words still to be written in the transfer
//     burst_cur   : beat count of the burst currently being issued
//     beat_idx    : index of the current beat within that burst
//     len_tail    : transfer length modulo the bytes per word
//     burst_next  : size of the next burst, min(MAX_BURST, words_rem)
//     byteenable  : byte lanes for the current beat
module wm_burst_sizer
  import write_master_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic [31:0]                  words_rem,
  input  logic [$clog2(MAX_BURST):0]   burst_cur,
  input  logic [$clog2(MAX_BURST):0]   beat_idx,
  input  logic [$clog2(DATA_W/8)-1:0]  len_tail,
  output logic [$clog2(MAX_BURST):0]   burst_next,
  output logic [DATA_W/8-1:0]          byteenable
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = $clog2(MAX_BURST) + 1;

  logic final_beat;

  always_comb begin
    if (words_rem >= 32'(MAX_BURST)) begin
      burst_next = BC_W'(MAX_BURST);
    end else begin
      // Below MAX_BURST the remaining count fits in the burstcount width.
      burst_next = words_rem[BC_W-1:0];
    end
  end

  // The final beat of the whole transfer is the last beat of the burst that
  // consumes every remaining word.
  assign final_beat = (words_rem == 32'(burst_cur)) &&
                      (beat_idx == burst_cur - 1'b1);

  assign byteenable = final_beat ? BYTES'(be_mask(32'(len_tail))) : '1;

endmodule

// File: rtl/write_master_burst.sv
// write_master_burst
//   Streams a byte-length transfer from an external show-ahead FIFO onto an
//   Avalon-MM style bursting write interface. The transfer is split into
//   bursts of at most MAX_BURST beats; each burst starts only when the FIFO
//   already holds the whole burst, so beats normally never wait on data.
//   Ports:
//     iClk, iReset          : clock, asynchronous active-high reset
//     iStart/iLength/iStartAddress : transfer request (bytes, byte address)
//     iFF_empty/iFF_level/iFF_q    : FIFO status and head word
//     oFF_readrequest       : FIFO pop, one per accepted beat
//     oWM_*                 : write master bus (write, address, data,
//                             byteenable, burstcount, waitrequest)
//     oWM_busy              : transfer in progress
//     oWM_done              : one-cycle completion pulse
module write_master_burst
  import write_master_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int LVL_W     = 8
) (
  input  logic                        iClk,
  input  logic                        iReset,
  input  logic                        iStart,
  input  logic [31:0]                 iLength,
  input  logic [ADDR_W-1:0]           iStartAddress,
  input  logic                        iFF_empty,
  input  logic [LVL_W-1:0]            iFF_level,
  input  logic [DATA_W-1:0]           iFF_q,
  output logic                        oFF_readrequest,
  output logic                        oWM_write,
  output logic [ADDR_W-1:0]           oWM_address,
  output logic [DATA_W-1:0]           oWM_writedata,
  output logic [DATA_W/8-1:0]         oWM_byteenable,
  output logic [$clog2(MAX_BURST):0]  oWM_burstcount,
  input  logic                        iWM_waitrequest,
  output logic                        oWM_busy,
  output logic                        oWM_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int LOG2B = $clog2(BYTES);
  localparam int BC_W  = $clog2(MAX_BURST) + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  wm_state_t         state;
  logic              write_r;
  logic              done_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       words_rem;
  logic [BC_W-1:0]   burst_r;
  logic [BC_W-1:0]   beat_idx;
  logic [LOG2B-1:0]  len_tail;
  logic [BC_W-1:0]   burst_next;
  logic [BYTES-1:0]  be_beat;
  logic              beat;
  logic [31:0]       start_words;

  wm_burst_sizer #(
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) u_sizer (
    .words_rem  (words_rem),
    .burst_cur  (burst_r),
    .beat_idx   (beat_idx),
    .len_tail   (len_tail),
    .burst_next (burst_next),
    .byteenable (be_beat)
  );

  // ceil(iLength / BYTES) without a divider.
  assign start_words = (iLength >> LOG2B) + 32'(|iLength[LOG2B-1:0]);

  // A beat is accepted only when the slave is ready and the FIFO really has
  // the word; an empty FIFO stalls the beat instead of popping nothing.
  assign beat            = write_r & ~iWM_waitrequest & ~iFF_empty;
  assign oFF_readrequest = beat;
  assign oWM_write       = write_r & ~iFF_empty;
  assign oWM_writedata   = write_r ? iFF_q : '0;
  assign oWM_byteenable  = write_r ? be_beat : '0;
  assign oWM_address     = addr_r;
  assign oWM_burstcount  = burst_r;
  assign oWM_busy        = (state != IDLE);
  assign oWM_done        = done_r;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state     <= IDLE;
      write_r   <= 1'b0;
      done_r    <= 1'b0;
      addr_r    <= '0;
      words_rem <= '0;
      burst_r   <= '0;
      beat_idx  <= '0;
      len_tail  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            addr_r    <= iStartAddress & ALIGN_MASK;
            words_rem <= start_words;
            len_tail  <= iLength[LOG2B-1:0];
            state     <= CALC;
          end
        end

        CALC: begin
          if (words_rem == 32'd0) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            burst_r  <= burst_next;
            beat_idx <= '0;
            state    <= WAIT_DATA;
          end
        end

        WAIT_DATA: begin
          if (32'(iFF_level) >= 32'(burst_r)) begin
            write_r <= 1'b1;
            state   <= BURST;
          end
        end

        BURST: begin
          if (beat) begin
            if (beat_idx == burst_r - 1'b1) begin
              // Burst complete: move the base past it and size the next one.
              write_r   <= 1'b0;
              addr_r    <= addr_r + (ADDR_W'(burst_r) << LOG2B);
              words_rem <= words_rem - 32'(burst_r);
              state     <= CALC;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end

        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          write_r <= 1'b0;
          done_r  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_master_burst.sv
module tb_write_master_burst;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_BURST = 8;
  localparam int LVL_W     = 8;
  localparam int BC_W      = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        be;
    logic [BC_W-1:0]   bc;
  } beat_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              iReset = 1'b1;
  logic              iStart = 1'b0;
  logic [31:0]       iLength = '0;
  logic [ADDR_W-1:0] iStartAddress = '0;
  logic              iWM_waitrequest = 1'b0;

  logic              oFF_readrequest;
  logic              oWM_write;
  logic [ADDR_W-1:0] oWM_address;
  logic [DATA_W-1:0] oWM_writedata;
  logic [3:0]        oWM_byteenable;
  logic [BC_W-1:0]   oWM_burstcount;
  logic              oWM_busy;
  logic              oWM_done;

  // External FIFO model: words written by the stimulus, popped by the DUT.
  logic [DATA_W-1:0] mem [0:63];
  logic [31:0]       wr_ptr = '0;
  logic [31:0]       rd_ptr = '0;
  logic              flush = 1'b0;
  logic              ff_empty;
  logic [LVL_W-1:0]  ff_level;
  logic [DATA_W-1:0] ff_q;

  assign ff_empty = (wr_ptr == rd_ptr);
  assign ff_level = LVL_W'(wr_ptr - rd_ptr);
  assign ff_q     = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (oFF_readrequest) rd_ptr <= rd_ptr + 1;
  end

  write_master_burst #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .LVL_W(LVL_W)
  ) dut (
    .iClk            (clk),
    .iReset          (iReset),
    .iStart          (iStart),
    .iLength         (iLength),
    .iStartAddress   (iStartAddress),
    .iFF_empty       (ff_empty),
    .iFF_level       (ff_level),
    .iFF_q           (ff_q),
    .oFF_readrequest (oFF_readrequest),
    .oWM_write       (oWM_write),
    .oWM_address     (oWM_address),
    .oWM_writedata   (oWM_writedata),
    .oWM_byteenable  (oWM_byteenable),
    .oWM_burstcount  (oWM_burstcount),
    .iWM_waitrequest (iWM_waitrequest),
    .oWM_busy        (oWM_busy),
    .oWM_done        (oWM_done)
  );

  beat_t             exp_q[$];
  chk_t              chk_q[$];
  logic [DATA_W-1:0] data_q[$];

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  logic [3:0]        last_be = '0;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [3:0]        prev_be = '0;

  // Monitor: the only process that steps the check counters.
  always @(negedge clk) begin : monitor
    chk_t  c;
    beat_t e;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s got %0h want %0h", c.name, c.act, c.exp);
      end
    end
    if (oWM_done) done_cnt++;
    if (iReset) begin
      checks++;
      if ({oWM_write, oFF_readrequest, oWM_address, oWM_writedata, oWM_byteenable,
           oWM_burstcount, oWM_busy, oWM_done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got write=%b pop=%b addr=%0h busy=%b want all 0",
                 oWM_write, oFF_readrequest, oWM_address, oWM_busy);
      end
      prev_stall <= 1'b0;
    end else begin
      if (oWM_write) begin
        checks++;
        if (oFF_readrequest !== (!iWM_waitrequest && !ff_empty)) begin
          errors++;
          $display("FAIL pop_rule got %b want %b", oFF_readrequest, !iWM_waitrequest);
        end
      end
      if (oFF_readrequest) begin
        beats_seen++;
        last_be <= oWM_byteenable;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got addr=%0h data=%0h want none", oWM_address, oWM_writedata);
        end else begin
          e = exp_q.pop_front();
          if (oWM_address !== e.addr || oWM_writedata !== e.data ||
              oWM_byteenable !== e.be || oWM_burstcount !== e.bc) begin
            errors++;
            $display("FAIL beat got a=%0h d=%0h be=%0h bc=%0d want a=%0h d=%0h be=%0h bc=%0d",
                     oWM_address, oWM_writedata, oWM_byteenable, oWM_burstcount,
                     e.addr, e.data, e.be, e.bc);
          end
        end
      end
      if (oWM_write && iWM_waitrequest) begin
        if (prev_stall) begin
          checks++;
          if (oWM_address !== prev_addr || oWM_writedata !== prev_data ||
              oWM_byteenable !== prev_be) begin
            errors++;
            $display("FAIL stall_hold got a=%0h d=%0h want a=%0h d=%0h",
                     oWM_address, oWM_writedata, prev_addr, prev_data);
          end
        end
        prev_stall <= 1'b1;
        prev_addr  <= oWM_address;
        prev_data  <= oWM_writedata;
        prev_be    <= oWM_byteenable;
      end else begin
        prev_stall <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  int seq = 0;

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[5:0]] = 32'hD000_0000 | DATA_W'(seq);
      data_q.push_back(32'hD000_0000 | DATA_W'(seq));
      seq++;
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Expected beat list for a transfer; returns the address after the last burst.
  task automatic expect_transfer(input logic [31:0] base, input logic [31:0] len,
                                 output logic [31:0] end_addr);
    logic [31:0] a;
    int rem, b;
    beat_t e;
    a   = base & ~32'h3;
    rem = int'((len + 32'd3) >> 2);
    while (rem > 0) begin
      b = (rem > MAX_BURST) ? MAX_BURST : rem;
      for (int i = 0; i < b; i++) begin
        e.addr = a;
        e.data = data_q.pop_front();
        e.bc   = BC_W'(b);
        if (rem == b && i == b - 1 && len[1:0] != 2'd0) e.be = (4'b0001 << len[1:0]) - 4'd1;
        else e.be = 4'hF;
        exp_q.push_back(e);
      end
      a   = a + 32'(b * 4);
      rem = rem - b;
    end
    end_addr = a;
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] len);
    @(posedge clk); #1;
    iStart        = 1'b1;
    iLength       = len;
    iStartAddress = base;
    @(posedge clk); #1;
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (oWM_done) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 64'(got), 64'd1);
  endtask

  task automatic wait_beats(input string name, input int target, input int max_cycles);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk); #1;
      if (beats_seen >= target) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, 64'(got), 64'd1);
  endtask

  initial begin : stim
    logic [31:0] end_a, rd0;
    int d0, b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 iReset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(oWM_busy), 64'd0);
    chk("idle_write", 64'(oWM_write), 64'd0);

    // 64 bytes, 16 words ready: two 8-beat bursts at base and base+32
    push_words(16);
    expect_transfer(32'h0000_1000, 32'd64, end_a);
    rd0 = rd_ptr; d0 = done_cnt;
    start(32'h0000_1000, 32'd64);
    @(negedge clk); chk("lat_calc_write", 64'(oWM_write), 64'd0);
    @(negedge clk); chk("lat_wait_write", 64'(oWM_write), 64'd0);
    @(negedge clk); chk("lat_first_write", 64'(oWM_write), 64'd1);
    chk("first_addr", 64'(oWM_address), 64'h1000);
    wait_done("done_64", 60);
    chk("end_addr_64", 64'(oWM_address), 64'h1040);
    repeat (3) @(negedge clk);
    chk("pops_64", 64'(rd_ptr - rd0), 64'd16);
    chk("done_once_64", 64'(done_cnt - d0), 64'd1);
    chk("drained_64", 64'(exp_q.size()), 64'd0);

    // 22 bytes from a misaligned base: one 6-beat burst, tail 2 bytes
    push_words(6);
    expect_transfer(32'h0000_2002, 32'd22, end_a);
    start(32'h0000_2002, 32'd22);
    wait_done("done_22", 40);
    chk("end_addr_22", 64'(oWM_address), 64'h2018);
    chk("last_be_22", 64'(last_be), 64'h3);
    chk("burstcount_22", 64'(oWM_burstcount), 64'd6);
    chk("drained_22", 64'(exp_q.size()), 64'd0);

    // Zero length: no write, done two cycles after iStart
    b0 = beats_seen;
    start(32'h0000_3000, 32'd0);
    @(negedge clk); chk("zero_calc_done", 64'(oWM_done), 64'd0);
    @(negedge clk); chk("zero_done", 64'(oWM_done), 64'd1);
    chk("zero_write", 64'(oWM_write), 64'd0);
    @(negedge clk); chk("zero_done_clear", 64'(oWM_done), 64'd0);
    chk("zero_beats", 64'(beats_seen - b0), 64'd0);

    // Three-cycle waitrequest mid-burst; a stray iStart must be ignored
    push_words(8);
    expect_transfer(32'h0000_4000, 32'd32, end_a);
    b0 = beats_seen;
    start(32'h0000_4000, 32'd32);
    wait_beats("stall_reach", b0 + 2, 30);
    @(posedge clk); #1;
    iWM_waitrequest = 1'b1;
    iStart = 1'b1; iLength = 32'd4; iStartAddress = 32'h0000_9000;
    rd0 = rd_ptr;
    @(posedge clk); #1;
    iStart = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("stall_no_pop", 64'(rd_ptr - rd0), 64'd0);
    chk("stall_write_held", 64'(oWM_write), 64'd1);
    iWM_waitrequest = 1'b0;
    wait_done("done_stall", 40);
    chk("end_addr_stall", 64'(oWM_address), 64'h4020);
    chk("drained_stall", 64'(exp_q.size()), 64'd0);

    // FIFO holds only 3 words for an 8-beat burst
    push_words(3);
    start(32'h0000_5000, 32'd32);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("level_wait_write", 64'(oWM_write), 64'd0);
    end
    chk("level_wait_busy", 64'(oWM_busy), 64'd1);
    @(posedge clk); #1;
    push_words(5);
    expect_transfer(32'h0000_5000, 32'd32, end_a);
    @(negedge clk); chk("level_edge_write", 64'(oWM_write), 64'd0);
    @(negedge clk); chk("level_go_write", 64'(oWM_write), 64'd1);
    wait_done("done_level", 40);
    chk("drained_level", 64'(exp_q.size()), 64'd0);

    // Reset at beat 4, then a clean transfer from a new base
    push_words(8);
    expect_transfer(32'h0000_6000, 32'd32, end_a);
    b0 = beats_seen; rd0 = rd_ptr;
    start(32'h0000_6000, 32'd32);
    wait_beats("reset_reach", b0 + 4, 30);
    @(posedge clk); #1;
    iReset = 1'b1;
    flush  = 1'b1;
    exp_q.delete();
    data_q.delete();
    #1;
    chk("rst_pops", 64'(rd_ptr - rd0), 64'd4);
    chk("rst_outputs", 64'({oWM_write, oFF_readrequest, oWM_byteenable, oWM_burstcount,
                            oWM_busy, oWM_done}), 64'd0);
    chk("rst_data_addr", {oWM_address, oWM_writedata}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    flush  = 1'b0;
    iReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resume_busy", 64'(oWM_busy), 64'd0);
    end
    push_words(4);
    expect_transfer(32'h0000_7000, 32'd16, end_a);
    d0 = done_cnt;
    start(32'h0000_7000, 32'd16);
    wait_done("done_after_rst", 40);
    chk("end_addr_rst", 64'(oWM_address), 64'h7010);
    repeat (3) @(negedge clk);
    chk("done_once_rst", 64'(done_cnt - d0), 64'd1);
    chk("drained_rst", 64'(exp_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
